// File: rtl/gbc_ppu_pkg.sv
// Shared PPU definitions: fetcher states, VRAM base addresses and CGB attribute bits.
// Defining GBC_CGB_ATTR_EN adds the attribute fetch states to the state enum.
package gbc_ppu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    MAP_A,
    MAP_D,
`ifdef GBC_CGB_ATTR_EN
    ATTR_A,
    ATTR_D,
`endif
    LO_A,
    LO_D,
    HI_A,
    HI_D,
    PUSH
  } fetch_state_e;

  localparam logic [12:0] MAP_BASE_0       = 13'h1800;
  localparam logic [12:0] MAP_BASE_1       = 13'h1C00;
  localparam logic [12:0] SIGNED_DATA_BASE = 13'h1000;

  localparam int ATTR_BANK_BIT  = 3;
  localparam int ATTR_XFLIP_BIT = 5;
  localparam int ATTR_YFLIP_BIT = 6;
  localparam int ATTR_PRIO_BIT  = 7;

  function automatic logic [7:0] bit_reverse(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Combinational VRAM address generation for the background tile fetcher:
// tile map entry address and tile data (low byte) address.
module tile_addr_gen
  import gbc_ppu_pkg::*;
(
  input  logic        tile_sel,
  input  logic        map_sel,
  input  logic [4:0]  scx_tile,
  input  logic [7:0]  scy,
  input  logic [7:0]  ly,
  input  logic [4:0]  tile_x,
  input  logic [7:0]  tile_idx,
  input  logic        y_flip,
  output logic [12:0] map_addr,
  output logic [12:0] data_addr
);

  logic [7:0] line_y;
  logic [2:0] row;
  logic [4:0] map_col;

  // The 5-bit column sum wraps 31->0 inside the same map row; the 13-bit
  // data sum wraps the signed-mode address around the 8 KiB bank.
  always_comb begin
    line_y  = ly + scy;
    row     = y_flip ? ~line_y[2:0] : line_y[2:0];
    map_col = scx_tile + tile_x;
    map_addr = (map_sel ? MAP_BASE_1 : MAP_BASE_0) + {3'b000, line_y[7:3], map_col};
    if (tile_sel)
      data_addr = {1'b0, tile_idx, row, 1'b0};
    else
      data_addr = SIGNED_DATA_BASE + {tile_idx[7], tile_idx, row, 1'b0};
  end

endmodule

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: walks one scanline of tiles through VRAM and hands each
// tile's bitplanes to the pixel FIFO. Define GBC_CGB_ATTR_EN for CGB attribute fetches.
module bg_tile_fetcher
  import gbc_ppu_pkg::*;
#(
  parameter int TILES_PER_LINE = 21
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        line_done,
  input  logic        tile_sel,
  input  logic        map_sel,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic [7:0]  ly,
  output logic        vram_rd,
  output logic [12:0] vram_addr,
  output logic        vram_bank,
  input  logic [7:0]  vram_data,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [7:0]  tile_lo,
  output logic [7:0]  tile_hi,
  output logic        tile_prio
);

  localparam logic [7:0] LAST_TILE = 8'(TILES_PER_LINE - 1);

  fetch_state_e state, next_state;

  logic        cfg_tile_sel, cfg_map_sel;
  logic [4:0]  cfg_scx_tile;
  logic [7:0]  cfg_scy, cfg_ly;
  logic [7:0]  tile_count;
  logic [7:0]  tile_idx;
  logic [7:0]  lo_q, hi_q;
  logic [12:0] map_addr, data_addr;
  logic        x_flip, y_flip, data_bank, prio;
  logic        last_tile;

`ifdef GBC_CGB_ATTR_EN
  logic attr_bank, attr_xflip, attr_yflip, attr_prio;
  assign x_flip    = attr_xflip;
  assign y_flip    = attr_yflip;
  assign data_bank = attr_bank;
  assign prio      = attr_prio;
`else
  assign x_flip    = 1'b0;
  assign y_flip    = 1'b0;
  assign data_bank = 1'b0;
  assign prio      = 1'b0;
`endif

  assign last_tile = (tile_count == LAST_TILE);
  assign busy      = (state != IDLE);
  assign tile_lo   = lo_q;
  assign tile_hi   = hi_q;
  assign tile_prio = prio;

  tile_addr_gen u_addr (
    .tile_sel  (cfg_tile_sel),
    .map_sel   (cfg_map_sel),
    .scx_tile  (cfg_scx_tile),
    .scy       (cfg_scy),
    .ly        (cfg_ly),
    .tile_x    (tile_count[4:0]),
    .tile_idx  (tile_idx),
    .y_flip    (y_flip),
    .map_addr  (map_addr),
    .data_addr (data_addr)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Abort overrides everything, including the request strobes of the current state.
  always_comb begin
    next_state = state;
    vram_rd    = 1'b0;
    vram_addr  = 13'd0;
    vram_bank  = 1'b0;
    tile_valid = 1'b0;
    case (state)
      IDLE:   if (start) next_state = MAP_A;
      MAP_A:  begin
        vram_rd    = 1'b1;
        vram_addr  = map_addr;
        next_state = MAP_D;
      end
`ifdef GBC_CGB_ATTR_EN
      MAP_D:  next_state = ATTR_A;
      ATTR_A: begin
        vram_rd    = 1'b1;
        vram_addr  = map_addr;
        vram_bank  = 1'b1;
        next_state = ATTR_D;
      end
      ATTR_D: next_state = LO_A;
`else
      MAP_D:  next_state = LO_A;
`endif
      LO_A:   begin
        vram_rd    = 1'b1;
        vram_addr  = data_addr;
        vram_bank  = data_bank;
        next_state = LO_D;
      end
      LO_D:   next_state = HI_A;
      HI_A:   begin
        vram_rd    = 1'b1;
        vram_addr  = data_addr | 13'd1;
        vram_bank  = data_bank;
        next_state = HI_D;
      end
      HI_D:   next_state = PUSH;
      PUSH:   begin
        tile_valid = 1'b1;
        if (tile_ready) next_state = last_tile ? IDLE : MAP_A;
      end
      default: next_state = IDLE;
    endcase
    if (abort) begin
      next_state = IDLE;
      vram_rd    = 1'b0;
      tile_valid = 1'b0;
    end
  end

  // Datapath: line configuration snapshot, fetched bytes and tile counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_tile_sel <= 1'b0;
      cfg_map_sel  <= 1'b0;
      cfg_scx_tile <= 5'd0;
      cfg_scy      <= 8'd0;
      cfg_ly       <= 8'd0;
      tile_count   <= 8'd0;
      tile_idx     <= 8'd0;
      lo_q         <= 8'd0;
      hi_q         <= 8'd0;
      line_done    <= 1'b0;
`ifdef GBC_CGB_ATTR_EN
      attr_bank    <= 1'b0;
      attr_xflip   <= 1'b0;
      attr_yflip   <= 1'b0;
      attr_prio    <= 1'b0;
`endif
    end else begin
      line_done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          cfg_tile_sel <= tile_sel;
          cfg_map_sel  <= map_sel;
          cfg_scx_tile <= scx[7:3];
          cfg_scy      <= scy;
          cfg_ly       <= ly;
          tile_count   <= 8'd0;
        end
        MAP_D: tile_idx <= vram_data;
`ifdef GBC_CGB_ATTR_EN
        ATTR_D: begin
          attr_bank  <= vram_data[ATTR_BANK_BIT];
          attr_xflip <= vram_data[ATTR_XFLIP_BIT];
          attr_yflip <= vram_data[ATTR_YFLIP_BIT];
          attr_prio  <= vram_data[ATTR_PRIO_BIT];
        end
`endif
        LO_D: lo_q <= x_flip ? bit_reverse(vram_data) : vram_data;
        HI_D: hi_q <= x_flip ? bit_reverse(vram_data) : vram_data;
        PUSH: if (tile_ready && !abort) begin
          tile_count <= tile_count + 8'd1;
          line_done  <= last_tile;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Scoreboard bench for bg_tile_fetcher: a VRAM model answers reads, a reference model
// queues the expected reads and tiles of each line, and monitors compare them.
module tb_bg_tile_fetcher;

  localparam int TILES = 21;
`ifdef GBC_CGB_ATTR_EN
  localparam int  READS_PER_TILE = 4;
  localparam int  LO_IDX         = 2;
  localparam bit  CGB            = 1'b1;
`else
  localparam int  READS_PER_TILE = 3;
  localparam int  LO_IDX         = 1;
  localparam bit  CGB            = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic        tile_sel = 1'b0, map_sel = 1'b0;
  logic [7:0]  scx = 8'd0, scy = 8'd0, ly = 8'd0;
  logic        tile_ready = 1'b1;
  logic        busy, line_done, vram_rd, vram_bank, tile_valid, tile_prio;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data = 8'd0;
  logic [7:0]  tile_lo, tile_hi;

  logic [7:0]  mem [0:1][0:8191];
  logic [13:0] exp_rd_q[$];
  logic [16:0] exp_tile_q[$];
  logic [13:0] read_log[$];
  logic [16:0] first_tile;
  int tests_run = 0, tests_failed = 0;
  int accepted = 0, done_pulses = 0, accepted_at_done = -1;

  always #5 clock = ~clock;

  bg_tile_fetcher #(.TILES_PER_LINE(TILES)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .line_done(line_done), .tile_sel(tile_sel), .map_sel(map_sel),
    .scx(scx), .scy(scy), .ly(ly), .vram_rd(vram_rd), .vram_addr(vram_addr),
    .vram_bank(vram_bank), .vram_data(vram_data), .tile_valid(tile_valid),
    .tile_ready(tile_ready), .tile_lo(tile_lo), .tile_hi(tile_hi), .tile_prio(tile_prio)
  );

  // VRAM model: read data appears the cycle after the request
  always @(posedge clock) vram_data <= vram_rd ? mem[vram_bank][vram_addr] : 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
    return r;
  endfunction

  // Monitors compare every VRAM read and every accepted tile against the scoreboard
  always @(negedge clock) begin
    if (vram_rd) begin
      read_log.push_back({vram_bank, vram_addr});
      if (exp_rd_q.size() == 0) checkOutput("extra_read", exp_rd_q.size(), 1);
      else checkOutput("vram_read", {vram_bank, vram_addr}, exp_rd_q.pop_front());
    end
    if (tile_valid && tile_ready) begin
      if (accepted == 0) first_tile = {tile_prio, tile_hi, tile_lo};
      accepted++;
      if (exp_tile_q.size() == 0) checkOutput("extra_tile", exp_tile_q.size(), 1);
      else checkOutput("tile_out", {tile_prio, tile_hi, tile_lo}, exp_tile_q.pop_front());
    end
    if (line_done) begin
      done_pulses++;
      accepted_at_done = accepted;
    end
  end

  // Reference model of one full line for the current configuration inputs
  task automatic push_line();
    logic [7:0]  y, idx, attr, lo, hi;
    logic [2:0]  row;
    logic [4:0]  col;
    logic [12:0] maddr, daddr;
    logic        bank;
    int          sidx;
    for (int t = 0; t < TILES; t++) begin
      y     = ly + scy;
      col   = scx[7:3] + 5'(t);
      maddr = (map_sel ? 13'h1C00 : 13'h1800) + 13'(y[7:3]) * 13'd32 + 13'(col);
      idx   = mem[0][maddr];
      attr  = CGB ? mem[1][maddr] : 8'h00;
      row   = attr[6] ? 3'd7 - y[2:0] : y[2:0];
      bank  = attr[3];
      sidx  = idx[7] ? int'(idx) - 256 : int'(idx);
      if (tile_sel) daddr = 13'(int'(idx) * 16 + int'(row) * 2);
      else          daddr = 13'((4096 + sidx * 16 + int'(row) * 2) & 8191);
      lo = mem[bank][daddr];
      hi = mem[bank][daddr + 13'd1];
      if (attr[5]) begin
        lo = rev8(lo);
        hi = rev8(hi);
      end
      exp_rd_q.push_back({1'b0, maddr});
      if (CGB) exp_rd_q.push_back({1'b1, maddr});
      exp_rd_q.push_back({bank, daddr});
      exp_rd_q.push_back({bank, daddr + 13'd1});
      exp_tile_q.push_back({attr[7], hi, lo});
    end
  endtask

  // Start a line with the given configuration, then scramble the config inputs
  task automatic applyStimulus(input logic ts, input logic ms, input logic [7:0] sx,
                               input logic [7:0] sy, input logic [7:0] l);
    @(posedge clock); #1;
    tile_sel = ts; map_sel = ms; scx = sx; scy = sy; ly = l;
    accepted = 0; done_pulses = 0; accepted_at_done = -1;
    read_log.delete();
    push_line();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    tile_sel = ~ts; map_sel = ~ms; scx = ~sx; scy = 8'($urandom); ly = ~l;
  endtask

  task automatic finish_line(input bit random_ready, input string tag);
    int cyc = 0;
    while (done_pulses == 0 && cyc < 3000) begin
      @(posedge clock); #1;
      tile_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (cyc == 30);
      cyc++;
    end
    tile_ready = 1'b1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checkOutput({tag, "_done_pulses"}, done_pulses, 1);
    checkOutput({tag, "_tiles_at_done"}, accepted_at_done, TILES);
    checkOutput({tag, "_reads_left"}, exp_rd_q.size(), 0);
    checkOutput({tag, "_busy_after"}, busy, 0);
  endtask

  function automatic logic [13:0] log_at(input int i);
    return (read_log.size() > i) ? read_log[i] : 14'h3FFF;
  endfunction

  task automatic flush();
    exp_rd_q.delete();
    exp_tile_q.delete();
    done_pulses = 0;
    accepted = 0;
  endtask

  initial begin
    int cyc;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 8192; a++) mem[b][a] = 8'($urandom);

    #12;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_vram_rd", vram_rd, 0);
    checkOutput("rst_line_done", line_done, 0);
    checkOutput("rst_tile_valid", tile_valid, 0);
    checkOutput("rst_tile_data", {tile_prio, tile_hi, tile_lo}, 0);
    checkOutput("rst_vram_bank_addr", {vram_bank, vram_addr}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Column wrap at scx=0xF8 and exact tile count
    mem[1][13'h181F] = 8'h00; mem[1][13'h1800] = 8'h00; mem[1][13'h1801] = 8'h00;
    applyStimulus(1'b1, 1'b0, 8'hF8, 8'h00, 8'h00);
    finish_line(1'b0, "wrap");
    checkOutput("wrap_map0", log_at(0), 14'h181F);
    checkOutput("wrap_map1", log_at(READS_PER_TILE), 14'h1800);
    checkOutput("wrap_map2", log_at(2 * READS_PER_TILE), 14'h1801);

    // Signed addressing with row 3
    mem[0][13'h1C00] = 8'h05; mem[1][13'h1C00] = 8'h00;
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h03);
    finish_line(1'b0, "signed");
    checkOutput("signed_lo", log_at(LO_IDX), 14'h1056);
    checkOutput("signed_hi", log_at(LO_IDX + 1), 14'h1057);

    // Negative signed index, then unsigned index
    mem[0][13'h1800] = 8'h96; mem[1][13'h1800] = 8'h00;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    finish_line(1'b0, "neg");
    checkOutput("neg_lo", log_at(LO_IDX), 14'h0960);
    mem[0][13'h1800] = 8'h05;
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    finish_line(1'b0, "unsigned");
    checkOutput("unsigned_lo", log_at(LO_IDX), 14'h0050);

`ifdef GBC_CGB_ATTR_EN
    // Attribute: bank 1, y-flip, x-flip and priority
    mem[0][13'h1800] = 8'h05; mem[1][13'h1800] = 8'hE8;
    mem[1][13'h005E] = 8'h01; mem[1][13'h005F] = 8'hC0;
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    finish_line(1'b0, "attr");
    checkOutput("attr_lo_read", log_at(LO_IDX), 14'h205E);
    checkOutput("attr_tile", first_tile, 17'h10380);
`endif

    // Random configurations with random back-pressure
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      finish_line(1'b1, "random");
    end

    // Back-pressure: PUSH held for 5 cycles with ready low
    tile_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h20, 8'h30);
    cyc = 0;
    while (!tile_valid && cyc < 50) begin @(negedge clock); cyc++; end
    checkOutput("stall_reached_push", tile_valid, 1);
    repeat (5) begin
      @(negedge clock);
      checkOutput("stall_valid", tile_valid, 1);
      checkOutput("stall_no_read", vram_rd, 0);
      checkOutput("stall_data", {tile_prio, tile_hi, tile_lo},
                  (exp_tile_q.size() > 0) ? exp_tile_q[0] : 17'h1FFFF);
    end
    finish_line(1'b0, "stall");

    // Abort in LO_D with a simultaneous start
    applyStimulus(1'b0, 1'b0, 8'h08, 8'h05, 8'h40);
    cyc = 0;
    while (read_log.size() < LO_IDX + 1 && cyc < 50) begin @(negedge clock); cyc++; end
    @(posedge clock); #1;
    abort = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0; start = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_vram_rd", vram_rd, 0);
    checkOutput("abort_valid", tile_valid, 0);
    @(posedge clock); #1;
    abort = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0; start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    checkOutput("abort_stays_idle", busy, 0);
    checkOutput("abort_no_line_done", done_pulses, 0);
    flush();

    // Reset mid-line: immediate idle, no resumption without start
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h10);
    repeat (12) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_vram_rd", vram_rd, 0);
    checkOutput("midrst_tile_data", {tile_prio, tile_hi, tile_lo}, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    flush();
    repeat (8) @(posedge clock);
    #1;
    checkOutput("midrst_no_resume", busy, 0);
    checkOutput("midrst_no_reads", read_log.size() > 0 ? exp_rd_q.size() : 0, 0);

    // A fresh line after reset works normally
    applyStimulus(1'b0, 1'b1, 8'h33, 8'h44, 8'h55);
    finish_line(1'b1, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bg_tile_fetcher.md
BG_TILE_FETCHER -- requirements
Module: bg_tile_fetcher

Interface
REQ-001 SHALL have parameter TILES_PER_LINE, default 21, meaning tile fetches per scanline (20 visible plus 1 for fine scroll).
REQ-002 SHALL have port clock, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports: start in 1 (line-fetch request pulse); abort in 1 (line end or LCD off); busy out 1; line_done out 1 (one-cycle pulse).
REQ-005 SHALL have config inputs: tile_sel in 1 (1 = unsigned base 0x0000, 0 = signed base 0x1000); map_sel in 1 (0 = map 0x1800, 1 = map 0x1C00); scx in 8; scy in 8; ly in 8.
REQ-006 SHALL have the VRAM port: vram_rd out 1; vram_addr out 13; vram_bank out 1; vram_data in 8 (valid the cycle after vram_rd).
REQ-007 SHALL have the output port: tile_valid out 1; tile_ready in 1; tile_lo out 8; tile_hi out 8; tile_prio out 1.

Function
REQ-008 SHALL use states IDLE, MAP_A, MAP_D, LO_A, LO_D, HI_A, HI_D, PUSH; each *_A state asserts vram_rd, and each *_D state captures vram_data.
REQ-009 SHALL move IDLE->MAP_A on start; then each state SHALL advance one per cycle MAP_A->MAP_D->LO_A->LO_D->HI_A->HI_D->PUSH.
REQ-010 SHALL, in PUSH, hold tile_valid=1 with stable tile_lo, tile_hi and tile_prio until tile_ready=1, and SHALL accept the transfer on the cycle where valid and ready are both 1.
REQ-011 SHALL, after acceptance, go to MAP_A when tiles fetched < TILES_PER_LINE, otherwise go to IDLE and pulse line_done for one cycle.
REQ-012 SHALL form the map address as base + (((ly+scy) mod 256)>>3)*32 + (((scx>>3)+tile_x) mod 32), so the column wraps 31->0 within the row.
REQ-013 SHALL form the data address as 0x0000 + idx*16 + row*2 when tile_sel=1, and as (0x1000 + sext(idx)*16 + row*2) mod 0x2000 when tile_sel=0; row = (ly+scy) mod 8, and the hi byte uses address +1.
REQ-014 SHALL sample scx, scy, ly, tile_sel and map_sel on start and hold them for the whole line.
REQ-015 SHALL, on abort in any state, deassert vram_rd and tile_valid and enter IDLE on the next edge with no line_done; abort SHALL win over a simultaneous start.
REQ-016 SHALL ignore start while busy; busy=1 in every state except IDLE.
REQ-017 SHALL drive vram_rd=0 in IDLE and PUSH, and vram_addr SHALL be don't-care when vram_rd=0.

Reset
REQ-018 SHALL, on reset_n low, immediately enter IDLE and clear the tile counter; vram_rd, busy, line_done, tile_valid, tile_lo, tile_hi, tile_prio, vram_bank and vram_addr SHALL all be 0.
REQ-019 SHALL, on reset release mid-line, resume only on a new start.

Configuration
REQ-020 SHALL support macro GBC_CGB_ATTR_EN.
- When defined: add states ATTR_A/ATTR_D between MAP_D and LO_A, reading the same map address with vram_bank=1.
- Attribute bit3 SHALL select vram_bank for the LO/HI reads.
- Attribute bit6 (y-flip) SHALL replace row with 7-row.
- Attribute bit5 (x-flip) SHALL bit-reverse tile_lo and tile_hi.
- Attribute bit7 SHALL drive tile_prio.
REQ-021 SHALL, when GBC_CGB_ATTR_EN is undefined, omit the ATTR states and tie vram_bank=0 and tile_prio=0.

Structure
REQ-022 SHALL define the state enum, the map base constants (0x1800, 0x1C00), the signed data base (0x1000) and the attribute bit positions in shared package gbc_ppu_pkg.
REQ-023 SHALL place the REQ-013 address computation in combinational sub-module tile_addr_gen.

Verification
REQ-024 tile_sel=0, idx=0x05, ly=3, scy=0 -> LO read at 0x1056 and HI read at 0x1057.
REQ-025 tile_sel=0, idx=0x96, row 0 -> LO read at 0x0960; tile_sel=1, idx=0x05, row 0 -> LO read at 0x0050.
REQ-026 map_sel=0, scx=0xF8, ly=0, scy=0 -> map reads 0x181F, then 0x1800, 0x1801 ...; line_done pulses after exactly 21 accepted tiles.
REQ-027 tile_ready held 0 for 5 cycles in PUSH -> tile_valid stays 1, outputs stay stable, and no vram_rd is issued.
REQ-028 abort asserted in LO_D -> IDLE next cycle, busy=0, and no line_done; a start in the same cycle as abort is ignored.
REQ-029 GBC_CGB_ATTR_EN defined, attr=0xE8, ly=0 -> bank-1 reads at row 7, tile_lo/tile_hi bit-reversed, tile_prio=1.
